// File: rtl/miner_pkg.sv
// Shared constants and types for the miner datapath: SHA padding, message length,
// second-chunk field offsets and the dispatcher state encoding.
package miner_pkg;

  localparam logic [31:0] SHA_PAD_WORD = 32'h8000_0000;
  localparam int unsigned MSG_LEN_BITS_DEFAULT = 640;

  localparam int unsigned MERKLE_TAIL_MSB = 511;
  localparam int unsigned NTIME_MSB       = 479;
  localparam int unsigned NBITS_MSB       = 447;
  localparam int unsigned NONCE_MSB       = 415;

  typedef enum logic [1:0] {IDLE, RUN, DONE} dispatch_state_t;

endpackage

// File: rtl/chunk2_pack.sv
// Builds the padded second 512-bit SHA-256 chunk of a block header for one nonce.
// NONCE_DISPATCH_BSWAP_EN: place the nonce byte-swapped (raw little-endian header order).
module chunk2_pack
  import miner_pkg::*;
#(
  parameter int unsigned MSG_LEN_BITS = MSG_LEN_BITS_DEFAULT
) (
  input  logic [95:0]  hdr_tail,
  input  logic [31:0]  nonce,
  output logic [511:0] M
);

  logic [31:0] nonce_w;

`ifdef NONCE_DISPATCH_BSWAP_EN
  assign nonce_w = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
`else
  assign nonce_w = nonce;
`endif

  always_comb begin
    M = '0;
    M[MERKLE_TAIL_MSB -: 32] = hdr_tail[95:64];
    M[NTIME_MSB -: 32]       = hdr_tail[63:32];
    M[NBITS_MSB -: 32]       = hdr_tail[31:0];
    M[NONCE_MSB -: 32]       = nonce_w;
    M[NONCE_MSB - 32 -: 32]  = SHA_PAD_WORD;
    M[31:0]                  = 32'(MSG_LEN_BITS);
  end

endmodule

// File: rtl/nonce_dispatch.sv
// Latches one mining job and issues one padded block per cycle to sha_block over a nonce range.
// Optional NONCE_DISPATCH_BSWAP_EN (see chunk2_pack) byte-swaps the nonce word inside M only.
module nonce_dispatch
  import miner_pkg::*;
#(
  parameter int unsigned NONCE_STEP   = 1,
  parameter int unsigned MSG_LEN_BITS = MSG_LEN_BITS_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         hold,
  input  logic [255:0] midstate_in,
  input  logic [95:0]  hdr_tail_in,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic         en,
  output logic [31:0]  nonce,
  output logic [511:0] M,
  output logic [255:0] H_prev,
  output logic         busy,
  output logic         done,
  output logic         exhausted,
  output logic [32:0]  issued_cnt
);

  dispatch_state_t state_q;
  logic [95:0]     hdr_q;
  logic [32:0]     end_q;
  // Next nonce to issue; 33 bits so stepping past 32'hFFFFFFFF cannot wrap.
  logic [32:0]     cand_q;
  logic [95:0]     pack_hdr;
  logic [31:0]     pack_nonce;
  logic [511:0]    pack_m;

  always_comb begin
    pack_hdr   = hdr_q;
    pack_nonce = cand_q[31:0];
    if (state_q != RUN) begin
      pack_hdr   = hdr_tail_in;
      pack_nonce = nonce_start;
    end
  end

  chunk2_pack #(
    .MSG_LEN_BITS(MSG_LEN_BITS)
  ) u_pack (
    .hdr_tail(pack_hdr),
    .nonce   (pack_nonce),
    .M       (pack_m)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      end_q      <= '0;
      cand_q     <= '0;
      en         <= 1'b0;
      nonce      <= '0;
      M          <= '0;
      H_prev     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      exhausted  <= 1'b0;
      issued_cnt <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            H_prev     <= midstate_in;
            hdr_q      <= hdr_tail_in;
            end_q      <= {1'b0, nonce_end};
            issued_cnt <= '0;
            en         <= 1'b0;
            if (nonce_start <= nonce_end) begin
              state_q   <= RUN;
              busy      <= 1'b1;
              done      <= 1'b0;
              exhausted <= 1'b0;
              if (!hold) begin
                en         <= 1'b1;
                nonce      <= nonce_start;
                M          <= pack_m;
                issued_cnt <= 33'd1;
                cand_q     <= {1'b0, nonce_start} + 33'(NONCE_STEP);
              end else begin
                cand_q <= {1'b0, nonce_start};
              end
            end else begin
              state_q   <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              exhausted <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_q   <= DONE;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            exhausted <= 1'b0;
          end else if (hold) begin
            en <= 1'b0;
          end else if (cand_q > end_q) begin
            state_q   <= DONE;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            exhausted <= 1'b1;
          end else begin
            en         <= 1'b1;
            nonce      <= cand_q[31:0];
            M          <= pack_m;
            issued_cnt <= issued_cnt + 33'd1;
            cand_q     <= cand_q + 33'(NONCE_STEP);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_dispatch.sv
// Directed self-checking bench for nonce_dispatch (step-1 instance plus a step-4 instance).
module tb_nonce_dispatch;

  logic         clk, reset, start, stop, hold;
  logic [255:0] midstate_in;
  logic [95:0]  hdr_tail_in;
  logic [31:0]  nonce_start, nonce_end;

  logic         en, busy, done, exhausted;
  logic [31:0]  nonce;
  logic [511:0] M;
  logic [255:0] H_prev;
  logic [32:0]  issued_cnt;

  logic         en4, busy4, done4, exhausted4;
  logic [31:0]  nonce4;
  logic [511:0] M4;
  logic [255:0] H_prev4;
  logic [32:0]  issued_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] MID   = {8{32'hA5A5_0000}} ^ 256'h1234_5678;
  localparam logic [95:0]  HDR   = 96'h45F4992E_74749054_747B1B18;
  localparam logic [31:0]  NTEST = 32'h43F740C0;
`ifdef NONCE_DISPATCH_BSWAP_EN
  localparam logic [31:0]  NWORD = 32'hC040F743;
`else
  localparam logic [31:0]  NWORD = 32'h43F740C0;
`endif
  localparam logic [511:0] M_EXP = {HDR, NWORD, 32'h8000_0000, 320'h0, 32'h0000_0280};

  nonce_dispatch dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .midstate_in(midstate_in), .hdr_tail_in(hdr_tail_in),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .en(en), .nonce(nonce), .M(M), .H_prev(H_prev), .busy(busy), .done(done),
    .exhausted(exhausted), .issued_cnt(issued_cnt)
  );

  nonce_dispatch #(.NONCE_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
    .midstate_in(midstate_in), .hdr_tail_in(hdr_tail_in),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .en(en4), .nonce(nonce4), .M(M4), .H_prev(H_prev4), .busy(busy4), .done(done4),
    .exhausted(exhausted4), .issued_cnt(issued_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] e);
    nonce_start = s;
    nonce_end   = e;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
    midstate_in = MID; hdr_tail_in = HDR; nonce_start = '0; nonce_end = '0;
    #2;
    check("rst_en", 512'(en), 512'(0));
    check("rst_M", M, 512'(0));
    check("rst_H_prev", 512'(H_prev), 512'(0));
    check("rst_cnt", 512'(issued_cnt), 512'(0));
    check("rst_flags", 512'({busy, done, exhausted, nonce}), 512'(0));
    check("rst_dut4", 512'({en4, busy4, done4, exhausted4, nonce4, issued_cnt4}), 512'(0));
    check("rst_dut4_M", M4 ^ 512'(H_prev4), 512'(0));
    step(); step();
    reset = 1'b0;
    step();

    // Four back-to-back issues, then done/exhausted one cycle later
    launch(32'h10, 32'h13);
    check("cnt_first", 512'({en, busy, nonce, issued_cnt}), 512'({1'b1, 1'b1, 32'h10, 33'd1}));
    check("cnt_hprev", 512'(H_prev), 512'(MID));
    for (int i = 1; i < 4; i++) begin
      step();
      check("cnt_issue", 512'({en, nonce, issued_cnt}), 512'({1'b1, 32'(32'h10 + i), 33'(i + 1)}));
    end
    step();
    check("cnt_done", 512'({en, busy, done, exhausted, issued_cnt}),
          512'({1'b0, 1'b0, 1'b1, 1'b1, 33'd4}));

    // Chunk content for the reference header, single-nonce range
    launch(NTEST, NTEST);
    check("m_content", M, M_EXP);
    check("m_nonce", 512'({en, nonce, issued_cnt}), 512'({1'b1, NTEST, 33'd1}));
    step();
    check("single_done", 512'({en, done, exhausted, issued_cnt}),
          512'({1'b0, 1'b1, 1'b1, 33'd1}));
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_in_done", 512'({en, busy, done, exhausted}), 512'({1'b0, 1'b0, 1'b1, 1'b1}));

    // Hold, start-while-RUN, stop
    launch(32'd0, 32'd99);
    for (int i = 1; i <= 5; i++) step();
    check("hold_pre", 512'({en, nonce, issued_cnt}), 512'({1'b1, 32'd5, 33'd6}));
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_off", 512'({en, nonce, issued_cnt}), 512'({1'b0, 32'd5, 33'd6}));
    end
    hold = 1'b0;
    for (int i = 6; i <= 20; i++) begin
      if (i == 10) begin
        nonce_start = 32'h500;
        nonce_end   = 32'h600;
        start       = 1'b1;
      end
      step();
      start = 1'b0;
      check("hold_resume", 512'({en, nonce, issued_cnt}), 512'({1'b1, 32'(i), 33'(i + 1)}));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop", 512'({en, busy, done, exhausted, issued_cnt}),
          512'({1'b0, 1'b0, 1'b1, 1'b0, 33'd21}));

    // Top of range must not wrap
    launch(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    check("top_0", 512'({en, nonce, issued_cnt}), 512'({1'b1, 32'hFFFF_FFFE, 33'd1}));
    step();
    check("top_1", 512'({en, nonce, issued_cnt}), 512'({1'b1, 32'hFFFF_FFFF, 33'd2}));
    step();
    check("top_done", 512'({en, done, exhausted, issued_cnt}), 512'({1'b0, 1'b1, 1'b1, 33'd2}));

    // Empty range
    launch(32'd5, 32'd4);
    check("empty", 512'({en, busy, done, exhausted, issued_cnt}),
          512'({1'b0, 1'b0, 1'b1, 1'b1, 33'd0}));
    step();
    check("empty_en", 512'({en, busy}), 512'(0));

    // Step-4 instance over 0..10
    launch(32'd0, 32'd10);
    check("step4_0", 512'({en4, nonce4}), 512'({1'b1, 32'd0}));
    step();
    check("step4_4", 512'({en4, nonce4}), 512'({1'b1, 32'd4}));
    step();
    check("step4_8", 512'({en4, nonce4, issued_cnt4}), 512'({1'b1, 32'd8, 33'd3}));
    step();
    check("step4_done", 512'({en4, done4, exhausted4, issued_cnt4}),
          512'({1'b0, 1'b1, 1'b1, 33'd3}));

    // Async reset mid-RUN, then restart with hold high on the start edge
    launch(32'd0, 32'd99);
    step(); step();
    reset = 1'b1;
    #1;
    check("async_rst", 512'({en, busy, done, exhausted, nonce, issued_cnt}), 512'(0));
    check("async_rst_M", M, 512'(0));
    check("async_rst_H", 512'(H_prev), 512'(0));
    reset = 1'b0;
    step();
    hold = 1'b1;
    launch(32'h30, 32'h31);
    check("restart_hold", 512'({en, busy, issued_cnt}), 512'({1'b0, 1'b1, 33'd0}));
    hold = 1'b0;
    step();
    check("restart_0", 512'({en, nonce, issued_cnt}), 512'({1'b1, 32'h30, 33'd1}));
    step();
    check("restart_1", 512'({en, nonce, issued_cnt}), 512'({1'b1, 32'h31, 33'd2}));
    step();
    check("restart_done", 512'({en, done, exhausted}), 512'({1'b0, 1'b1, 1'b1}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nonce_dispatch.md
Name: nonce_dispatch

Overview:
- Upstream feeder for the pipelined sha_block in the bitcoin_miner path.
- Latches one job: midstate, 96-bit header tail and an inclusive nonce range.
- Builds the padded second 512-bit chunk for each nonce and issues one block per cycle on en/nonce/M/H_prev.
- Stops on range exhaustion or on an external stop (found/abort).

Parameters:
NONCE_STEP, 1, nonce increment per issue (lets several cores split a range)
MSG_LEN_BITS, 640, header length placed in M[31:0] (32'h00000280)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  job start pulse; sampled in IDLE/DONE only
stop  in  1  found/abort; sampled in RUN only
hold  in  1  back-pressure; no issue while high
midstate_in  in  256  H after first chunk, latched on start
hdr_tail_in  in  96  {merkle_tail, ntime, nbits}, latched on start
nonce_start  in  32  first nonce, latched on start
nonce_end  in  32  last nonce (inclusive), latched on start
en  out  1  block valid to sha_block.en
nonce  out  32  nonce of issued block (to sha_block.nonce)
M  out  512  {merkle_tail, ntime, nbits, nonce_w, 32'h80000000, 320'h0, MSG_LEN_BITS[31:0]}
H_prev  out  256  latched midstate
busy  out  1  high in RUN
done  out  1  high in DONE
exhausted  out  1  valid with done: 1 = range completed, 0 = stopped
issued_cnt  out  33  blocks issued in current job

Behaviour:
- Reset (async, any time, including mid-job): state IDLE. All outputs 0, including M, H_prev and issued_cnt. Any in-flight issue is dropped.
- States are IDLE, RUN and DONE. All outputs are registered.
- IDLE/DONE, start=1 at edge k, nonce_start <= nonce_end:
  - latch job and go to RUN;
  - at edge k, en=1, nonce=nonce_start, issued_cnt=1, unless hold=1 at edge k;
  - clear done and exhausted.
- IDLE/DONE, start=1 with nonce_start > nonce_end: go straight to DONE with exhausted=1, issued_cnt=0, and never assert en.
- RUN, each edge:
  - stop=1 → DONE, en=0, exhausted=0. Stop has priority over hold and over issuing.
  - else hold=1 → en=0; nonce, M and issued_cnt are held.
  - else if the last issued nonce + NONCE_STEP > nonce_end (33-bit compare, so 32'hFFFFFFFF never wraps) → DONE, en=0, exhausted=1.
  - else issue nonce+NONCE_STEP with en=1 and issued_cnt+1.
- First issue while hold was high at start: nonce_start is issued on the first edge with hold=0.
- Throughput: one block per cycle while hold=0. en is a one-cycle-per-block qualifier; a back-to-back stream keeps en high.
- nonce_end == nonce_start: exactly one issue, then DONE/exhausted on the next edge.
- start while RUN is ignored. stop in IDLE/DONE is ignored.
- Full range 0..FFFFFFFF with step 1: issued_cnt reaches 33'h1_0000_0000.
- H_prev and the hdr_tail fields of M are stable for the whole job.

Optional Feature:
NONCE_DISPATCH_BSWAP_EN
- Defined: nonce_w in M is the byte-swapped nonce ({n[7:0],n[15:8],n[23:16],n[31:24]}), matching raw little-endian header order. The nonce port stays unswapped.
- Undefined: nonce_w = nonce.

Decomposition:
- Shared package miner_pkg holds:
  - SHA_PAD_WORD (32'h80000000);
  - the default message-length constant;
  - the M field offsets (MERKLE_TAIL_MSB=511, NTIME_MSB=479, NBITS_MSB=447, NONCE_MSB=415);
  - typedef enum dispatch_state_t {IDLE, RUN, DONE}.
- One sub-module: chunk2_pack (combinational). Inputs are hdr_tail and nonce; output is M. It contains the bswap ifdef.

Test Plan:
- Issue count: start, nonce 0x10..0x13, hold=0 → en high 4 consecutive cycles with nonce 10,11,12,13. done=1, exhausted=1 and issued_cnt=4 one cycle after the last issue.
- M content: hdr_tail=45F4992E_74749054_747B1B18, nonce 0x43F740C0 → M equals 512'h45F4992E74749054747B1B1843F740C08000…0280 (the macro changes only the nonce word).
- End-to-end: same job fed into sha_block with midstate → H equals F4A4F827…B87254E3, and nonce_out=0x43F740C0.
- Hold and stop: range 0..99 with hold pulsed for 3 cycles at nonce 5 → no en for 3 cycles, then 6 resumes. stop at nonce 20 → en low next cycle, done=1, exhausted=0, issued_cnt=21.
- Range edges: range FFFFFFFE..FFFFFFFF → 2 issues, no wrap, exhausted=1. start=5, end=4 → done, issued_cnt=0, en never high. NONCE_STEP=4 with range 0..10 → nonces 0, 4, 8.
- Reset and restart: assert reset mid-RUN → all outputs 0 asynchronously. A new start after reset runs correctly. start during RUN is ignored.
